// File: rtl/serial_tx_framer.sv
// Serial transmit framer: start bit, N data bits LSB first, optional even
// parity bit, stop bit; each bit held for DIV clock cycles.
module serial_tx_framer #(
    parameter int unsigned N   = 4,
    parameter int unsigned DIV = 4,
    parameter int unsigned PAR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d_in,
    input  logic         valid,
    output logic         ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = $clog2(N);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic [N-1:0]  shreg, shreg_nxt;
    logic          par_q, par_nxt;
    logic          tx_nxt;
    logic          done_nxt;
    logic          last_tick;

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign last_tick = (cnt == CW'(DIV - 1));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par_q   <= par_nxt;
            tx      <= tx_nxt;
            done    <= done_nxt;
        end
    end

    // tx is computed from the next state so the line changes on the same edge as the state
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par_q;
        tx_nxt      = tx;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (valid) begin
                    state_nxt   = START;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = d_in;
                    par_nxt     = ^d_in;
                    tx_nxt      = 1'b0;
                end
            end
            START: begin
                if (last_tick) begin
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    cnt_nxt   = '0;
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == BW'(N - 1)) begin
                        if (PAR != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        tx_nxt      = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (last_tick) begin
                    cnt_nxt   = '0;
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: three configurations, hand-computed
// serial bit sequences, back-to-back, mid-frame valid and mid-frame reset.
module tb_serial_tx_framer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] d_a;  logic valid_a;  logic ready_a, tx_a, busy_a, done_a;
    logic [3:0] d_b;  logic valid_b;  logic ready_b, tx_b, busy_b, done_b;
    logic [7:0] d_c;  logic valid_c;  logic ready_c, tx_c, busy_c, done_c;

    serial_tx_framer #(.N(4), .DIV(4), .PAR(0)) u_a (
        .clk(clk), .rst(rst), .d_in(d_a), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));
    serial_tx_framer #(.N(4), .DIV(2), .PAR(1)) u_b (
        .clk(clk), .rst(rst), .d_in(d_b), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));
    serial_tx_framer #(.N(8), .DIV(1), .PAR(0)) u_c (
        .clk(clk), .rst(rst), .d_in(d_c), .valid(valid_c),
        .ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c));

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int done_cnt_a = 0;
    int base;

    logic tx_m, busy_m, ready_m, done_m;
    always_comb begin
        case (sel)
            1:       {tx_m, busy_m, ready_m, done_m} = {tx_b, busy_b, ready_b, done_b};
            2:       {tx_m, busy_m, ready_m, done_m} = {tx_c, busy_c, ready_c, done_c};
            default: {tx_m, busy_m, ready_m, done_m} = {tx_a, busy_a, ready_a, done_a};
        endcase
    end

    always @(posedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the selected block idle; returns at the first start-bit cycle
    task automatic send(input int s, input logic [7:0] d);
        sel = s;
        case (s)
            1:       begin d_b = d[3:0]; valid_b = 1'b1; end
            2:       begin d_c = d;      valid_c = 1'b1; end
            default: begin d_a = d[3:0]; valid_a = 1'b1; end
        endcase
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    endtask

    // seq[i] is the i-th serial bit; returns at the done cycle
    task automatic check_frame(input string name, input int div, input int nb,
                               input logic [15:0] seq, input int glitch);
        for (int k = 1; k <= nb * div; k++) begin
            if (glitch != 0 && k == glitch) begin
                valid_a = 1'b1; d_a = 4'h0;
            end else if (glitch != 0 && k == glitch + 1) begin
                valid_a = 1'b0;
            end
            chk($sformatf("%s tx c%0d", name, k), 32'(tx_m), 32'(seq[(k - 1) / div]));
            chk($sformatf("%s busy c%0d", name, k), 32'(busy_m), 32'd1);
            chk($sformatf("%s ready c%0d", name, k), 32'(ready_m), 32'd0);
            chk($sformatf("%s done c%0d", name, k), 32'(done_m), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("%s done pulse", name), 32'(done_m), 32'd1);
        chk($sformatf("%s ready end", name), 32'(ready_m), 32'd1);
        chk($sformatf("%s busy end", name), 32'(busy_m), 32'd0);
        chk($sformatf("%s tx idle", name), 32'(tx_m), 32'd1);
    endtask

    initial begin
        d_a = '0; d_b = '0; d_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;

        // asynchronous reset takes effect before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst tx", 32'(tx_a), 32'd1);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst ready", 32'(ready_a), 32'd1);
        chk("rst done", 32'(done_a), 32'd0);
        chk("rst tx_c", 32'(tx_c), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle tx", 32'(tx_b), 32'd1);
        chk("idle ready", 32'(ready_b), 32'd1);

        // N=4 DIV=4: 1011 -> 0 | 1 1 0 1 | 1
        send(0, 8'h0B);
        check_frame("a1011", 4, 6, 16'b110110, 0);
        @(negedge clk);
        chk("a done once", 32'(done_a), 32'd0);

        // N=4 DIV=2 PAR=1: 0111 -> 0 | 1 1 1 0 | p=1 | 1
        send(1, 8'h07);
        check_frame("b0111", 2, 7, 16'b1101110, 0);
        @(negedge clk);

        // N=8 DIV=1: A5 -> 0 1 0 1 0 0 1 0 1 1
        send(2, 8'hA5);
        check_frame("cA5", 1, 10, 16'b1101001010, 0);
        @(negedge clk);

        // valid pulsed with a different word mid-frame is ignored
        send(0, 8'h0B);
        check_frame("a_glitch", 4, 6, 16'b110110, 10);
        @(negedge clk);
        chk("a glitch not latched", 32'(busy_a), 32'd0);

        // valid held high: B presented in A's done cycle follows with no gap
        base = done_cnt_a;
        sel = 0;
        d_a = 4'hB; valid_a = 1'b1;
        @(negedge clk);
        check_frame("b2b_A", 4, 6, 16'b110110, 0);
        d_a = 4'b0100;
        @(negedge clk);
        valid_a = 1'b0;
        check_frame("b2b_B", 4, 6, 16'b101000, 0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b done count", 32'(done_cnt_a - base), 32'd2);

        // reset in DATA aborts immediately with no done pulse
        base = done_cnt_a;
        send(0, 8'h0B);
        repeat (7) @(negedge clk);
        chk("pre-rst busy", 32'(busy_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst tx", 32'(tx_a), 32'd1);
        chk("midrst busy", 32'(busy_a), 32'd0);
        chk("midrst ready", 32'(ready_a), 32'd1);
        chk("midrst done", 32'(done_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst no done", 32'(done_cnt_a - base), 32'd0);

        // 0110 -> 0 | 0 1 1 0 | 1
        send(0, 8'h06);
        check_frame("a_post_rst", 4, 6, 16'b101100, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
